rtclapwatch: RTL and testbench
==============================

# rtclapwatch

Parametrised BCD stopwatch/countdown timer with lap capture, for the RTC core alongside the clock and timer. It derives a 100 Hz tick from the same 32-bit `i_ckstep` that drives the clock. It counts hundredths, seconds, minutes and a configurable number of hour digits, either up, or down from a loaded value with an alarm at zero. Lap snapshots are buffered in a small FIFO for the bus wrapper to drain.

## Interface
- `HRDIGITS`, default 2: number of BCD hour digits, 1..3; sets `VW = 24 + 4*HRDIGITS`.
- `LGLAPS`, default 2: log2 of lap FIFO depth (depth `2**LGLAPS`), 1..4.
- `i_clk`  in  1  sole clock.
- `i_reset_n`  in  1  reset, synchronous and active-low.
- `i_ckstep`  in  32  per-clock step, same as the clock core: bottom 32 bits of a 48-bit step rolling over once per second.
- `i_clear`  in  1  zero the counter and the accumulator, flush the laps, force up-mode.
- `i_start`, `i_stop`  in  1  run control pulses.
- `i_load`  in  1  load `i_load_value` and enter down-mode.
- `i_load_value`  in  VW  BCD preset.
- `i_lap`  in  1  capture the current value into the lap FIFO.
- `i_lap_rd`  in  1  pop the lap FIFO head.
- `o_value`  out  VW  current BCD count.
- `o_running`  out  1  counting.
- `o_down`  out  1  down-mode active.
- `o_alarm`  out  1  one-cycle pulse when the countdown reaches zero.
- `o_wrap`  out  1  one-cycle pulse on up-count rollover.
- `o_lderr`  out  1  one-cycle pulse on a rejected load.
- `o_lap_valid`  out  1  FIFO non-empty.
- `o_lap_data`  out  VW  FIFO head, valid with `o_lap_valid`.
- `o_lap_ovfl`  out  1  sticky: a lap was dropped because the FIFO was full.

## Operation
- Digit layout:
  - [3:0] hundredths, 0-9.
  - [7:4] tenths, 0-9.
  - [11:8] seconds, 0-9.
  - [14:12] tens of seconds, 0-5; bit 15 = 0.
  - [19:16] minutes, 0-9.
  - [22:20] tens of minutes, 0-5; bit 23 = 0.
  - [VW-1:24] hour digits, each 0-9.
  - Bits 15 and 23 always read 0.
- Tick generator:
  - `step = 100*i_ckstep` is registered, 39 bits, one cycle of latency.
  - A 48-bit accumulator adds `step` every cycle that `(o_running && !i_stop) || i_start`.
  - A carry out of bit 47 is the tick.
  - The accumulator holds while stopped and is zeroed by clear, load or reset.
- Up-mode: each tick adds 1 with BCD carry through all digits. At all-max (99:59:59.99 for HRDIGITS=2) the count wraps to 0, keeps running, and `o_wrap` pulses.
- Down-mode: each tick subtracts 1 with BCD borrow.
  - When the result is 0: the counter becomes 0, `o_running` clears, and `o_alarm` pulses in the same cycle the counter becomes 0.
  - `i_start` in down-mode with the counter already 0 is ignored.
- Load:
  - Every digit is checked against its limit; bits 15 and 23 must be 0.
  - If any check fails, the load is ignored, `o_lderr` pulses, and all state is unchanged.
  - A legal load sets the counter, `o_down = 1`, and `o_running = 0`.
- Control priority, same cycle: reset > clear > load > stop > start.
  - Clear does not change `o_running`.
  - Start and stop together resolve to stop.
- Lap capture:
  - `i_lap` pushes the `o_value` present in that cycle, regardless of running.
  - If the FIFO is full with no pop in the same cycle, the capture is dropped and `o_lap_ovfl` is set.
  - Pop and push in the same cycle when full: both succeed.
  - A pop when empty is ignored.
  - `o_lap_ovfl` is cleared only by clear or reset.

## Timing
- On reset (`i_reset_n = 0` at a clock edge), all outputs are 0 and the FIFO is empty.
- `i_start` at cycle N: `o_running = 1` at N+1.
- `i_stop` at N: `o_running = 0` at N+1, and no count update at N+1 from a tick raised at N.
- Tick latency: the accumulator carry is registered at cycle T; `o_value`, `o_wrap` and `o_alarm` update at T+1.
- Lap: `o_lap_valid` rises the cycle after a push into an empty FIFO. `o_lap_data` is the registered FIFO head, which advances the cycle after `i_lap_rd`.
- Clear or load at N takes effect at N+1. A tick arriving at N is discarded.
- Reset mid-count or mid-FIFO: everything returns to reset values at the next edge.

## Structure
- Shared package `rtc_pkg`:
  - digit limit constants: 9, 5;
  - the `VW` width function;
  - the field offsets of the digit layout.
- One sub-module, `rtcbcdstep`, instantiated per digit:
  - parameter `MAX`;
  - inputs: digit, up/down, carry-in;
  - outputs: next digit, carry-out.
- The lap FIFO is inline: a register array plus pointers with one extra wrap bit each.

## Test plan
- Rate check: `i_ckstep = 32'd2814749767`, start, run 100 000 cycles → `o_value` ≈ 0x00000100 (1.00 s), ±1 hundredth.
- Up-count rollover: `HRDIGITS=2`, load is not used; force via a stepped run from 99:59:59.98 reached in fast-tick mode (`i_ckstep = 32'hFFFFFFFF`). Required sequence: 0x99595999 → 0x00000000, with `o_wrap` high for exactly 1 cycle and `o_running` still 1.
- Countdown: load 0x00000003, start → values 2, 1, 0 on successive ticks; `o_alarm` pulses with value 0; `o_running = 0`; a further start is ignored.
- Illegal load: `i_load_value = 0x0000_6000` (tens of seconds = 6) → `o_lderr` pulse, `o_value` and `o_down` unchanged.
- Lap FIFO, `LGLAPS = 2`:
  - 5 laps without reads → 4 stored, `o_lap_ovfl = 1`, pops return the first 4 values in order;
  - simultaneous lap + pop when full → no overflow.
- Priority and reset: start + stop in the same cycle → not running. Clear while running → value 0, still running. `i_reset_n = 0` mid-count → all outputs 0 next cycle.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC stopwatch core.
// Holds the per-digit limits, the field offsets of the BCD digit layout,
// the value-width function, and a helper that maps a digit index to its limit.
package rtc_pkg;

    localparam logic [3:0] DIGIT_MAX9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX5 = 4'd5;

    localparam int OFS_HUNDREDTHS = 0;
    localparam int OFS_TENTHS     = 4;
    localparam int OFS_SECS       = 8;
    localparam int OFS_TENSECS    = 12;
    localparam int OFS_MINS       = 16;
    localparam int OFS_TENMINS    = 20;
    localparam int OFS_HOURS      = 24;

    function automatic int vw(input int hrdigits);
        return OFS_HOURS + 4 * hrdigits;
    endfunction

    // Tens-of-seconds and tens-of-minutes stop at 5; every other digit,
    // hours included, stops at 9. A limit of 5 also rejects bits 15/23.
    function automatic logic [3:0] digit_limit(input int idx);
        case (idx * 4)
            OFS_HUNDREDTHS, OFS_TENTHS, OFS_SECS, OFS_MINS: return DIGIT_MAX9;
            OFS_TENSECS, OFS_TENMINS:                       return DIGIT_MAX5;
            default:                                        return DIGIT_MAX9;
        endcase
    endfunction

endpackage

// File: rtl/rtcbcdstep.sv
// One BCD digit of the stopwatch counter: increments or decrements a digit
// when the carry/borrow input is set, wrapping at MAX.
// Ports:
//   digit  in  4  current digit
//   up     in  1  1 = count up, 0 = count down
//   cin    in  1  carry (up) or borrow (down) into this digit
//   nxt    out 4  digit after the step
//   cout   out 1  carry/borrow into the next digit
module rtcbcdstep #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic [3:0] digit,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] nxt,
    output logic       cout
);

    always_comb begin
        nxt  = digit;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit >= MAX) begin
                    nxt  = 4'd0;
                    cout = 1'b1;
                end else begin
                    nxt = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    nxt  = MAX;
                    cout = 1'b1;
                end else begin
                    nxt = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/rtclapwatch.sv
// BCD stopwatch / countdown timer with lap capture.
// A 100 Hz tick is derived from the clock core's per-cycle step; the count
// runs up (wrapping at all-max) or down from a loaded value (alarm at zero).
// Lap snapshots go into a small FIFO drained by the bus wrapper.
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_ckstep                  per-clock step, 2**48 per second
//   i_clear/i_start/i_stop    run control pulses
//   i_load, i_load_value      preset and enter down-mode
//   i_lap, i_lap_rd           push current value / pop lap FIFO head
//   o_value                   BCD count
//   o_running, o_down         status
//   o_alarm, o_wrap, o_lderr  one-cycle event pulses
//   o_lap_valid, o_lap_data   lap FIFO head
//   o_lap_ovfl                sticky lap-dropped flag
module rtclapwatch
    import rtc_pkg::*;
#(
    parameter int HRDIGITS = 2,
    parameter int LGLAPS   = 2,
    localparam int VW      = rtc_pkg::vw(HRDIGITS)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [31:0]   i_ckstep,
    input  logic          i_clear,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_load,
    input  logic [VW-1:0] i_load_value,
    input  logic          i_lap,
    input  logic          i_lap_rd,
    output logic [VW-1:0] o_value,
    output logic          o_running,
    output logic          o_down,
    output logic          o_alarm,
    output logic          o_wrap,
    output logic          o_lderr,
    output logic          o_lap_valid,
    output logic [VW-1:0] o_lap_data,
    output logic          o_lap_ovfl
);

    localparam int ND    = VW / 4;
    localparam int DEPTH = 2 ** LGLAPS;

    logic [38:0]   step;
    logic [47:0]   acc;
    logic [48:0]   acc_sum;
    logic          acc_en;
    logic          tick;

    logic [VW-1:0] count, count_nxt, stepped;
    logic [ND:0]   carry;
    logic          running, running_nxt;
    logic          down, down_nxt;
    logic          alarm, alarm_nxt, wrap, wrap_nxt, lderr, lderr_nxt;
    logic          load_ok, load_take, load_bad;

    logic [VW-1:0]   laps [DEPTH];
    logic [LGLAPS:0] wptr, rptr;
    logic            lap_empty, lap_full, lap_push, lap_pop, ovfl;

    // Tick generator: carry out of the 48-bit accumulator is the 100 Hz tick.
    assign acc_sum   = {1'b0, acc} + {10'd0, step};
    assign acc_en    = (running && !i_stop) || i_start;
    assign load_take = i_load && load_ok;
    assign load_bad  = i_load && !load_ok;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            step <= '0;
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            step <= {7'd0, i_ckstep} * 39'd100;
            if (i_clear || load_take) begin
                acc  <= '0;
                tick <= 1'b0;
            end else if (!load_bad) begin
                // A rejected load freezes everything, pending tick included.
                tick <= acc_en && acc_sum[48];
                if (acc_en) begin
                    acc <= acc_sum[47:0];
                end
            end
        end
    end

    // Digit chain: carry[0] is the "step by one" request.
    assign carry[0] = 1'b1;
    for (genvar i = 0; i < ND; i++) begin : g_digit
        rtcbcdstep #(.MAX(digit_limit(i))) u_step (
            .digit (count[4*i +: 4]),
            .up    (!down),
            .cin   (carry[i]),
            .nxt   (stepped[4*i +: 4]),
            .cout  (carry[i+1])
        );
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (i_load_value[4*i +: 4] > digit_limit(i)) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        count_nxt   = count;
        running_nxt = running;
        down_nxt    = down;
        alarm_nxt   = 1'b0;
        wrap_nxt    = 1'b0;
        lderr_nxt   = 1'b0;
        if (i_clear) begin
            count_nxt = '0;
            down_nxt  = 1'b0;
        end else if (i_load) begin
            if (load_ok) begin
                count_nxt   = i_load_value;
                down_nxt    = 1'b1;
                running_nxt = 1'b0;
            end else begin
                lderr_nxt = 1'b1;
            end
        end else if (i_stop) begin
            running_nxt = 1'b0;
        end else begin
            if (i_start && !(down && count == '0)) begin
                running_nxt = 1'b1;
            end
            if (tick && running) begin
                count_nxt = stepped;
                if (down) begin
                    if (stepped == '0) begin
                        running_nxt = 1'b0;
                        alarm_nxt   = 1'b1;
                    end
                end else if (carry[ND]) begin
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count   <= '0;
            running <= 1'b0;
            down    <= 1'b0;
            alarm   <= 1'b0;
            wrap    <= 1'b0;
            lderr   <= 1'b0;
        end else begin
            count   <= count_nxt;
            running <= running_nxt;
            down    <= down_nxt;
            alarm   <= alarm_nxt;
            wrap    <= wrap_nxt;
            lderr   <= lderr_nxt;
        end
    end

    // Lap FIFO: pointers carry one extra bit to tell full from empty.
    assign lap_empty = (wptr == rptr);
    assign lap_full  = (wptr[LGLAPS] != rptr[LGLAPS]) &&
                       (wptr[LGLAPS-1:0] == rptr[LGLAPS-1:0]);
    assign lap_pop   = i_lap_rd && !lap_empty;
    assign lap_push  = i_lap && (!lap_full || lap_pop);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wptr <= '0;
            rptr <= '0;
            ovfl <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                laps[i] <= '0;
            end
        end else if (i_clear) begin
            wptr <= '0;
            rptr <= '0;
            ovfl <= 1'b0;
        end else begin
            if (lap_push) begin
                laps[wptr[LGLAPS-1:0]] <= count;
                wptr <= wptr + {{LGLAPS{1'b0}}, 1'b1};
            end
            if (lap_pop) begin
                rptr <= rptr + {{LGLAPS{1'b0}}, 1'b1};
            end
            if (i_lap && !lap_push) begin
                ovfl <= 1'b1;
            end
        end
    end

    assign o_value     = count;
    assign o_running   = running;
    assign o_down      = down;
    assign o_alarm     = alarm;
    assign o_wrap      = wrap;
    assign o_lderr     = lderr;
    assign o_lap_valid = !lap_empty;
    assign o_lap_data  = laps[rptr[LGLAPS-1:0]];
    assign o_lap_ovfl  = ovfl;

endmodule

// File: tb/tb_rtclapwatch.sv
// Directed bench for rtclapwatch (HRDIGITS=2, LGLAPS=2).
module tb_rtclapwatch;

    localparam int HRDIGITS = 2;
    localparam int LGLAPS   = 2;
    localparam int VW       = 24 + 4 * HRDIGITS;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   ckstep;
    logic          clear, start, stop, load, lap, lap_rd;
    logic [VW-1:0] load_value;
    logic [VW-1:0] value, lap_data;
    logic          running, down, alarm, wrap, lderr, lap_valid, lap_ovfl;
    logic          seen;

    logic [31:0] lapv [5] = '{32'h101, 32'h202, 32'h303, 32'h404, 32'h505};

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    rtclapwatch #(.HRDIGITS(HRDIGITS), .LGLAPS(LGLAPS)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_ckstep     (ckstep),
        .i_clear      (clear),
        .i_start      (start),
        .i_stop       (stop),
        .i_load       (load),
        .i_load_value (load_value),
        .i_lap        (lap),
        .i_lap_rd     (lap_rd),
        .o_value      (value),
        .o_running    (running),
        .o_down       (down),
        .o_alarm      (alarm),
        .o_wrap       (wrap),
        .o_lderr      (lderr),
        .o_lap_valid  (lap_valid),
        .o_lap_data   (lap_data),
        .o_lap_ovfl   (lap_ovfl)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_change(input logic [VW-1:0] from, input int budget, output logic got_it);
        got_it = 1'b0;
        for (int i = 0; i < budget && !got_it; i++) begin
            clk_step();
            if (value != from) got_it = 1'b1;
        end
    endtask

    task automatic do_load(input logic [VW-1:0] v);
        load_value = v;
        load = 1'b1;
        clk_step();
        load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ckstep = '0; clear = 0; start = 0; stop = 0;
        load = 0; lap = 0; lap_rd = 0; load_value = '0;
        repeat (2) clk_step();
        check("rst_value",     64'(value),     64'h0);
        check("rst_running",   64'(running),   64'h0);
        check("rst_down",      64'(down),      64'h0);
        check("rst_alarm",     64'(alarm),     64'h0);
        check("rst_wrap",      64'(wrap),      64'h0);
        check("rst_lderr",     64'(lderr),     64'h0);
        check("rst_lap_valid", 64'(lap_valid), 64'h0);
        check("rst_lap_data",  64'(lap_data),  64'h0);
        check("rst_lap_ovfl",  64'(lap_ovfl),  64'h0);
        reset_n = 1'b1;

        // Rate: 100 kHz clock, 10000 adds -> 0.10 s within one hundredth
        ckstep = 32'd2814749767;
        clk_step();
        start = 1; clk_step(); start = 0;
        check("start_running", 64'(running), 64'h1);
        repeat (9999) clk_step();
        check("rate_0p10s", 64'(value >= 32'h09 && value <= 32'h11), 64'h1);
        stop = 1; clk_step(); stop = 0;
        check("stop", 64'(running), 64'h0);
        start = 1; stop = 1; clk_step(); start = 0; stop = 0;
        check("start_stop", 64'(running), 64'h0);
        start = 1; clk_step(); start = 0;
        repeat (50) clk_step();
        clear = 1; clk_step(); clear = 0;
        check("clear_value",   64'(value),   64'h0);
        check("clear_running", 64'(running), 64'h1);
        check("clear_down",    64'(down),    64'h0);
        stop = 1; clk_step(); stop = 0;

        // Countdown with exact tick timing: ticks after 656, 1311, 1967 adds
        ckstep = 32'hFFFFFFFF;
        clk_step();
        do_load(32'h3);
        check("cd_load_value", 64'(value),   64'h3);
        check("cd_load_down",  64'(down),    64'h1);
        start = 1; clk_step(); start = 0;
        check("cd_running", 64'(running), 64'h1);
        repeat (655) clk_step();
        check("cd_hold3", 64'(value), 64'h3);
        clk_step();
        check("cd_2", 64'(value), 64'h2);
        repeat (654) clk_step();
        check("cd_hold2", 64'(value), 64'h2);
        clk_step();
        check("cd_1", 64'(value), 64'h1);
        repeat (655) clk_step();
        check("cd_hold1", 64'(value), 64'h1);
        check("cd_no_alarm", 64'(alarm), 64'h0);
        clk_step();
        check("cd_0",       64'(value),   64'h0);
        check("cd_alarm",   64'(alarm),   64'h1);
        check("cd_stopped", 64'(running), 64'h0);
        clk_step();
        check("cd_alarm_once", 64'(alarm), 64'h0);
        start = 1; clk_step(); start = 0;
        check("start_at_zero", 64'(running), 64'h0);

        // Loads: legal, then rejected ones leave state alone
        do_load(32'h1234);
        check("load_1234", 64'(value), 64'h1234);
        do_load(32'h6000);
        check("ld6000_err",   64'(lderr), 64'h1);
        check("ld6000_value", 64'(value), 64'h1234);
        check("ld6000_down",  64'(down),  64'h1);
        clk_step();
        check("lderr_once", 64'(lderr), 64'h0);
        do_load(32'h8000);
        check("ld8000_err", 64'(lderr), 64'h1);
        clear = 1; clk_step(); clear = 0;
        do_load(32'hA0000000);
        check("ldhr_err",  64'(lderr), 64'h1);
        check("ldhr_down", 64'(down),  64'h0);
        do_load(32'h99595999);
        check("ldmax_err",   64'(lderr), 64'h0);
        check("ldmax_value", 64'(value), 64'h99595999);

        // Up-count rollover from 99:59:59.98
        clear = 1; clk_step(); clear = 0;
        start = 1; clk_step(); start = 0;
        force dut.count_nxt = 32'h99595998;
        clk_step();
        release dut.count_nxt;
        wait_change(32'h99595998, 1000, seen);
        check("wrap_tick1_seen", 64'(seen),  64'h1);
        check("wrap_pre",        64'(value), 64'h99595999);
        check("wrap_pre_pulse",  64'(wrap),  64'h0);
        wait_change(32'h99595999, 1000, seen);
        check("wrap_tick2_seen", 64'(seen),    64'h1);
        check("wrap_value",      64'(value),   64'h0);
        check("wrap_pulse",      64'(wrap),    64'h1);
        check("wrap_running",    64'(running), 64'h1);
        clk_step();
        check("wrap_once", 64'(wrap), 64'h0);
        stop = 1; clk_step(); stop = 0;

        // Lap FIFO: five captures into four slots
        clear = 1; clk_step(); clear = 0;
        check("lap_flush", 64'(lap_valid), 64'h0);
        for (int i = 0; i < 5; i++) begin
            do_load(lapv[i]);
            lap = 1; clk_step(); lap = 0;
            if (i == 0) begin
                check("lap_first_valid", 64'(lap_valid), 64'h1);
                check("lap_first_data",  64'(lap_data),  64'h101);
            end
        end
        check("lap_ovfl", 64'(lap_ovfl), 64'h1);
        for (int i = 0; i < 4; i++) begin
            check("lap_pop_data", 64'(lap_data), 64'(lapv[i]));
            lap_rd = 1; clk_step(); lap_rd = 0;
        end
        check("lap_drained", 64'(lap_valid), 64'h0);
        lap_rd = 1; clk_step(); lap_rd = 0;
        check("lap_pop_empty", 64'(lap_valid), 64'h0);
        check("lap_ovfl_sticky", 64'(lap_ovfl), 64'h1);
        clear = 1; clk_step(); clear = 0;
        check("lap_ovfl_clear", 64'(lap_ovfl), 64'h0);
        for (int i = 1; i <= 4; i++) begin
            do_load(32'(i));
            lap = 1; clk_step(); lap = 0;
        end
        do_load(32'h5);
        lap = 1; lap_rd = 1; clk_step(); lap = 0; lap_rd = 0;
        check("lap_pushpop_ovfl", 64'(lap_ovfl), 64'h0);
        for (int i = 0; i < 4; i++) begin
            check("lap_pushpop_data", 64'(lap_data), 64'(i + 2));
            lap_rd = 1; clk_step(); lap_rd = 0;
        end
        check("lap_pushpop_drained", 64'(lap_valid), 64'h0);

        // Reset mid-count with a lap stored
        do_load(32'h50);
        start = 1; clk_step(); start = 0;
        repeat (700) clk_step();
        check("borrow_49", 64'(value), 64'h49);
        lap = 1; clk_step(); lap = 0;
        reset_n = 1'b0; clk_step();
        check("mid_rst_value",     64'(value),     64'h0);
        check("mid_rst_running",   64'(running),   64'h0);
        check("mid_rst_down",      64'(down),      64'h0);
        check("mid_rst_lap_valid", 64'(lap_valid), 64'h0);
        check("mid_rst_lap_data",  64'(lap_data),  64'h0);
        reset_n = 1'b1;
        clk_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
